// File: rtl/keypad_scanner.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | keypad_scanner: one-hot row scanner with frame-level debounce and key       |
// | reporting over a valid/ack handshake.                   Revision 1.0        |
// +-----------------------------------------------------------------------------+
module keypad_scanner #(
  parameter  int ROWS     = 4,
  parameter  int COLS     = 4,
  parameter  int DWELL    = 4,
  parameter  int DEBOUNCE = 3,
  localparam int CODE_W   = $clog2(ROWS * COLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [COLS-1:0]   col_in,
  input  logic              key_ack,
  output logic [ROWS-1:0]   row_drv,
  output logic              key_valid,
  output logic [CODE_W-1:0] key_code,
  output logic              key_held,
  output logic              key_overflow
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int DW_W  = $clog2(DWELL);
  localparam int STB_W = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_SINGLE = 2'd1,
    CLS_MULTI  = 2'd2
  } cls_e;

  logic [ROW_W-1:0]  row_idx_q, row_idx_d;
  logic [DW_W-1:0]   dwell_cnt_q, dwell_cnt_d;
  cls_e              acc_cls_q, acc_cls_d;
  logic [CODE_W-1:0] acc_code_q, acc_code_d;
  cls_e              cand_cls_q, cand_cls_d;
  logic [CODE_W-1:0] cand_code_q, cand_code_d;
  logic [STB_W-1:0]  stable_cnt_q, stable_cnt_d;
  logic              reported_q, reported_d;
  logic [CODE_W-1:0] held_code_q, held_code_d;
  logic              key_valid_q, key_valid_d;
  logic [CODE_W-1:0] key_code_q, key_code_d;
  logic              key_held_q, key_held_d;
  logic              key_overflow_q, key_overflow_d;

  logic [1:0]        samp_n;
  logic [CODE_W-1:0] samp_col;
  logic [CODE_W-1:0] samp_code;
  cls_e              samp_cls;
  cls_e              res_cls;
  logic [CODE_W-1:0] res_code;
  logic              sample_now;
  logic              frame_close;

  always_comb begin
    row_drv = '0;
    if (en) row_drv[row_idx_q] = 1'b1;
  end

  // Classify the current row sample and merge it into the running frame result.
  always_comb begin
    samp_n   = 2'd0;
    samp_col = '0;
    for (int c = 0; c < COLS; c++) begin
      if (col_in[c]) begin
        samp_n   = (samp_n == 2'd2) ? 2'd2 : samp_n + 2'd1;
        samp_col = CODE_W'(c);
      end
    end
    samp_code = CODE_W'(int'(row_idx_q) * COLS) + samp_col;
    case (samp_n)
      2'd0:    samp_cls = CLS_NONE;
      2'd1:    samp_cls = CLS_SINGLE;
      default: samp_cls = CLS_MULTI;
    endcase
    if (acc_cls_q == CLS_NONE)      res_cls = samp_cls;
    else if (samp_cls == CLS_NONE)  res_cls = acc_cls_q;
    else                            res_cls = CLS_MULTI;
    res_code = '0;
    if (res_cls == CLS_SINGLE) res_code = (acc_cls_q == CLS_SINGLE) ? acc_code_q : samp_code;
  end

  assign sample_now  = (dwell_cnt_q == DW_W'(DWELL - 1));
  assign frame_close = sample_now && (row_idx_q == ROW_W'(ROWS - 1));

  always_comb begin
    row_idx_d      = row_idx_q;
    dwell_cnt_d    = dwell_cnt_q;
    acc_cls_d      = acc_cls_q;
    acc_code_d     = acc_code_q;
    cand_cls_d     = cand_cls_q;
    cand_code_d    = cand_code_q;
    stable_cnt_d   = stable_cnt_q;
    reported_d     = reported_q;
    held_code_d    = held_code_q;
    key_valid_d    = key_valid_q;
    key_code_d     = key_code_q;
    key_held_d     = key_held_q;
    key_overflow_d = 1'b0;

    if (key_valid_q && key_ack) key_valid_d = 1'b0;

    if (!en) begin
      row_idx_d    = '0;
      dwell_cnt_d  = '0;
      acc_cls_d    = CLS_NONE;
      acc_code_d   = '0;
      cand_cls_d   = CLS_NONE;
      cand_code_d  = '0;
      stable_cnt_d = '0;
      reported_d   = 1'b0;
      key_held_d   = 1'b0;
    end else if (!sample_now) begin
      dwell_cnt_d = dwell_cnt_q + DW_W'(1);
    end else begin
      dwell_cnt_d = '0;
      row_idx_d   = (row_idx_q == ROW_W'(ROWS - 1)) ? '0 : row_idx_q + ROW_W'(1);
      if (!frame_close) begin
        acc_cls_d  = res_cls;
        acc_code_d = res_code;
      end else begin
        acc_cls_d  = CLS_NONE;
        acc_code_d = '0;
        if (res_cls == cand_cls_q && res_code == cand_code_q) begin
          if (stable_cnt_q != STB_W'(DEBOUNCE)) stable_cnt_d = stable_cnt_q + STB_W'(1);
        end else begin
          cand_cls_d   = res_cls;
          cand_code_d  = res_code;
          stable_cnt_d = STB_W'(1);
        end
        // A debounced frame state either accepts a fresh key or retires the held one.
        if (stable_cnt_d == STB_W'(DEBOUNCE)) begin
          if (cand_cls_d == CLS_SINGLE) begin
            if (!reported_q) begin
              reported_d  = 1'b1;
              key_held_d  = 1'b1;
              held_code_d = cand_code_d;
              if (!key_valid_q || key_ack) begin
                key_valid_d = 1'b1;
                key_code_d  = cand_code_d;
              end else begin
                key_overflow_d = 1'b1;
              end
            end else if (cand_code_d != held_code_q) begin
              key_held_d = 1'b0;
            end
          end else begin
            key_held_d = 1'b0;
            if (cand_cls_d == CLS_NONE) reported_d = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_idx_q      <= '0;
      dwell_cnt_q    <= '0;
      acc_cls_q      <= CLS_NONE;
      acc_code_q     <= '0;
      cand_cls_q     <= CLS_NONE;
      cand_code_q    <= '0;
      stable_cnt_q   <= '0;
      reported_q     <= 1'b0;
      held_code_q    <= '0;
      key_valid_q    <= 1'b0;
      key_code_q     <= '0;
      key_held_q     <= 1'b0;
      key_overflow_q <= 1'b0;
    end else begin
      row_idx_q      <= row_idx_d;
      dwell_cnt_q    <= dwell_cnt_d;
      acc_cls_q      <= acc_cls_d;
      acc_code_q     <= acc_code_d;
      cand_cls_q     <= cand_cls_d;
      cand_code_q    <= cand_code_d;
      stable_cnt_q   <= stable_cnt_d;
      reported_q     <= reported_d;
      held_code_q    <= held_code_d;
      key_valid_q    <= key_valid_d;
      key_code_q     <= key_code_d;
      key_held_q     <= key_held_d;
      key_overflow_q <= key_overflow_d;
    end
  end

  assign key_valid    = key_valid_q;
  assign key_code     = key_code_q;
  assign key_held     = key_held_q;
  assign key_overflow = key_overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_keypad_scanner: directed vector bench for keypad_scanner (4x4, DWELL 4,  |
// | DEBOUNCE 3) with a keypad model closing columns on the driven row. Rev 1.0  |
// +-----------------------------------------------------------------------------+
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  col_in;
  logic        key_ack;
  logic [3:0]  row_drv;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic        key_overflow;
  logic [15:0] keys;

  int checks = 0;
  int errors = 0;

  keypad_scanner #(.ROWS(4), .COLS(4), .DWELL(4), .DEBOUNCE(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .col_in       (col_in),
    .key_ack      (key_ack),
    .row_drv      (row_drv),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_held     (key_held),
    .key_overflow (key_overflow)
  );

  always #5 clk = ~clk;

  // Physical keypad: bit r*4+c of keys closes column c while row r is strobed.
  always_comb begin
    col_in = '0;
    for (int r = 0; r < 4; r++)
      if (row_drv[r]) col_in = col_in | keys[r*4 +: 4];
  end

  typedef struct {
    logic        en;
    logic        ack;
    logic [15:0] keys;
    int          cycles;
    logic [3:0]  row;
    logic        valid;
    logic [3:0]  code;
    logic        held;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic a, input logic [15:0] k, input int n, input logic [3:0] r,
                     input logic v, input logic [3:0] c, input logic h, input logic o);
    vec_t t;
    t.en = 1'b1; t.ack = a; t.keys = k; t.cycles = n;
    t.row = r; t.valid = v; t.code = c; t.held = h; t.ovf = o;
    vecs.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] r, input logic v,
                         input logic [3:0] c, input logic h, input logic o);
    chk({tag, " row_drv"},      32'(row_drv),      32'(r));
    chk({tag, " key_valid"},    32'(key_valid),    32'(v));
    chk({tag, " key_code"},     32'(key_code),     32'(c));
    chk({tag, " key_held"},     32'(key_held),     32'(h));
    chk({tag, " key_overflow"}, 32'(key_overflow), 32'(o));
  endtask

  localparam logic [15:0] K0  = 16'h0000;
  localparam logic [15:0] K9  = 16'h0200;
  localparam logic [15:0] K15 = 16'h8000;
  localparam logic [15:0] K05 = 16'h0021;

  initial begin
    // Scan sequence with no key (cycle counts track the absolute clock after reset release).
    add(0, K0, 1, 4'b0001, 0, 0, 0, 0);   // T=1
    add(0, K0, 2, 4'b0001, 0, 0, 0, 0);   // T=3
    add(0, K0, 1, 4'b0010, 0, 0, 0, 0);   // T=4
    add(0, K0, 3, 4'b0010, 0, 0, 0, 0);   // T=7
    add(0, K0, 1, 4'b0100, 0, 0, 0, 0);   // T=8
    add(0, K0, 4, 4'b1000, 0, 0, 0, 0);   // T=12
    add(0, K0, 3, 4'b1000, 0, 0, 0, 0);   // T=15
    add(0, K0, 1, 4'b0001, 0, 0, 0, 0);   // T=16
    // Clean press of code 9, hold, ack, release.
    add(0, K9, 47, 4'b1000, 0, 0, 0, 0);  // T=63
    add(0, K9, 1, 4'b0001, 1, 9, 1, 0);   // T=64
    add(0, K9, 160, 4'b0001, 1, 9, 1, 0); // T=224
    add(1, K9, 1, 4'b0001, 0, 9, 1, 0);   // T=225
    add(0, K0, 46, 4'b1000, 0, 9, 1, 0);  // T=271
    add(0, K0, 1, 4'b0001, 0, 9, 0, 0);   // T=272
    // Bounce: 2 present, 1 absent, 3 present.
    add(0, K9, 32, 4'b0001, 0, 9, 0, 0);  // T=304
    add(0, K0, 16, 4'b0001, 0, 9, 0, 0);  // T=320
    add(0, K9, 47, 4'b1000, 0, 9, 0, 0);  // T=367
    add(0, K9, 1, 4'b0001, 1, 9, 1, 0);   // T=368
    add(1, K9, 1, 4'b0001, 0, 9, 1, 0);   // T=369
    add(0, K9, 31, 4'b0001, 0, 9, 1, 0);  // T=400
    // Release, then two keys together is never reported.
    add(0, K0, 48, 4'b0001, 0, 9, 0, 0);  // T=448
    add(0, K05, 80, 4'b0001, 0, 9, 0, 0); // T=528
    add(0, K0, 48, 4'b0001, 0, 9, 0, 0);  // T=576
    // Overflow: code 9 unacked when code 15 is accepted.
    add(0, K9, 48, 4'b0001, 1, 9, 1, 0);  // T=624
    add(0, K0, 48, 4'b0001, 1, 9, 0, 0);  // T=672
    add(0, K15, 47, 4'b1000, 1, 9, 0, 0); // T=719
    add(0, K15, 1, 4'b0001, 1, 9, 1, 1);  // T=720
    add(0, K15, 1, 4'b0001, 1, 9, 1, 0);  // T=721
    add(1, K15, 1, 4'b0001, 0, 9, 1, 0);  // T=722
    // Ack on the accept edge loads the new key.
    add(0, K0, 46, 4'b0001, 0, 9, 0, 0);  // T=768
    add(0, K9, 48, 4'b0001, 1, 9, 1, 0);  // T=816
    add(0, K0, 48, 4'b0001, 1, 9, 0, 0);  // T=864
    add(0, K15, 47, 4'b1000, 1, 9, 0, 0); // T=911
    add(1, K15, 1, 4'b0001, 1, 15, 1, 0); // T=912
    add(1, K15, 1, 4'b0001, 0, 15, 1, 0); // T=913
    // Pending key, then park on row 2 mid-dwell.
    add(0, K0, 47, 4'b0001, 0, 15, 0, 0); // T=960
    add(0, K9, 48, 4'b0001, 1, 9, 1, 0);  // T=1008
    add(0, K9, 9, 4'b0100, 1, 9, 1, 0);   // T=1017

    rst = 1'b0; en = 1'b1; key_ack = 1'b0; keys = K0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all("reset", 4'b0001, 0, 0, 0, 0);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      en = vecs[i].en; key_ack = vecs[i].ack; keys = vecs[i].keys;
      repeat (vecs[i].cycles) @(posedge clk);
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), vecs[i].row, vecs[i].valid, vecs[i].code,
              vecs[i].held, vecs[i].ovf);
    end

    // Asynchronous reset mid-dwell with key_valid pending.
    key_ack = 1'b0;
    rst = 1'b0;
    #1;
    chk_all("async_rst", 4'b0001, 0, 0, 0, 0);
    @(negedge clk);
    chk_all("rst_hold", 4'b0001, 0, 0, 0, 0);
    rst = 1'b1; keys = K9;
    repeat (48) @(posedge clk);
    @(negedge clk);
    chk_all("post_rst_press", 4'b0001, 1, 9, 1, 0);

    // Disable keeps the pending key but drops scanning and key_held.
    en = 1'b0;
    #1;
    chk("en0 row_drv", 32'(row_drv), 32'(4'b0000));
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk_all("en0_hold", 4'b0000, 1, 9, 0, 0);
    key_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    key_ack = 1'b0;
    chk_all("en0_ack", 4'b0000, 0, 9, 0, 0);

    // Re-enable restarts at row 0, dwell 0.
    keys = K0; en = 1'b1;
    #1;
    chk("reen row0", 32'(row_drv), 32'(4'b0001));
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("reen row1", 32'(row_drv), 32'(4'b0010));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
